// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction sequencer.
// State encoding, default widths and a saturating adder used by stock and revenue paths.
package vend_pkg;

  localparam int NUM_TYPES_D = 8;
  localparam int PRICE_W_D   = 4;
  localparam int STOCK_W_D   = 4;
  localparam int CREDIT_W_D  = 5;
  localparam int ACC_W_D     = 8;
  localparam int TYPE_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    DISPENSE,
    CHANGE
  } state_t;

  // Callers zero-extend into 16 bits and truncate the result back to their own width.
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] max);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[15:0];
  endfunction

endpackage

// File: rtl/vend_stock_table.sv
// Per-type stock register file: saturating restock port, decrement port, two combinational reads.
// Writes land on the next clk edge; restock and decrement never target the same cycle.
module vend_stock_table
  import vend_pkg::*;
#(
  parameter int NUM_TYPES = NUM_TYPES_D,
  parameter int STOCK_W   = STOCK_W_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restock_en,
  input  logic [TYPE_W-1:0]  restock_type,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               dec_en,
  input  logic [TYPE_W-1:0]  dec_type,
  input  logic [STOCK_W-1:0] dec_qty,
  input  logic [TYPE_W-1:0]  rd_type,
  output logic [STOCK_W-1:0] rd_data,
  input  logic [TYPE_W-1:0]  chk_type,
  output logic [STOCK_W-1:0] chk_data
);

  localparam logic [15:0] STOCK_MAX = 16'((1 << STOCK_W) - 1);

  logic [STOCK_W-1:0] stock [NUM_TYPES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TYPES; i++) stock[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TYPES; i++) begin
        if (restock_en && restock_type == TYPE_W'(i))
          stock[i] <= STOCK_W'(sat_add(16'(stock[i]), 16'(restock_qty), STOCK_MAX));
        else if (dec_en && dec_type == TYPE_W'(i))
          stock[i] <= stock[i] - dec_qty;
      end
    end
  end

  assign rd_data  = stock[rd_type];
  assign chk_data = stock[chk_type];

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, price/stock check, dispense and change phases.
// CHECK and CHANGE take one cycle, DISPENSE one cycle per unit; coins arriving while busy are rejected.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_TYPES = NUM_TYPES_D,
  parameter int PRICE_W   = PRICE_W_D,
  parameter int STOCK_W   = STOCK_W_D,
  parameter int CREDIT_W  = CREDIT_W_D,
  parameter int ACC_W     = ACC_W_D
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_TYPES*PRICE_W-1:0]   price_flat,
  input  logic                           coin_valid,
  input  logic [3:0]                     coin_value,
  input  logic                           sel_valid,
  input  logic [TYPE_W-1:0]              sel_type,
  input  logic [STOCK_W-1:0]             sel_amount,
  input  logic                           cancel,
  input  logic                           restock_valid,
  input  logic [TYPE_W-1:0]              restock_type,
  input  logic [STOCK_W-1:0]             restock_qty,
  output logic                           busy,
  output logic                           red_light,
  output logic                           coin_reject,
  output logic                           dispense_valid,
  output logic [TYPE_W-1:0]              dispense_type,
  output logic                           change_valid,
  output logic [CREDIT_W-1:0]            change_amount,
  output logic [CREDIT_W-1:0]            credit,
  output logic [ACC_W-1:0]               machine_acc,
  input  logic [TYPE_W-1:0]              stock_rd_type,
  output logic [STOCK_W-1:0]             stock_rd_data
);

  localparam int COST_W = PRICE_W + STOCK_W;
  localparam logic [CREDIT_W:0] CREDIT_MAX = (CREDIT_W+1)'((1 << CREDIT_W) - 1);
  localparam logic [15:0]       ACC_MAX    = 16'((1 << ACC_W) - 1);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [ACC_W-1:0]    acc_nxt;
  logic                red_nxt, rej_nxt;
  logic [TYPE_W-1:0]   lat_type, lat_type_nxt;
  logic [STOCK_W-1:0]  lat_amt, lat_amt_nxt, cnt, cnt_nxt;
  logic                restock_en, dec_en;
  logic [STOCK_W-1:0]  chk_stock;
  logic [PRICE_W-1:0]  price_sel;
  logic [COST_W-1:0]   cost;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits, accept;

  vend_stock_table #(.NUM_TYPES(NUM_TYPES), .STOCK_W(STOCK_W)) u_stock (
    .clk          (clk),
    .rst_n        (rst_n),
    .restock_en   (restock_en),
    .restock_type (restock_type),
    .restock_qty  (restock_qty),
    .dec_en       (dec_en),
    .dec_type     (lat_type),
    .dec_qty      (lat_amt),
    .rd_type      (stock_rd_type),
    .rd_data      (stock_rd_data),
    .chk_type     (lat_type),
    .chk_data     (chk_stock)
  );

  // Full-width product: a truncated cost could let an expensive order pass the credit check.
  assign price_sel = price_flat[lat_type*PRICE_W +: PRICE_W];
  assign cost      = COST_W'(price_sel) * COST_W'(lat_amt);
  assign coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
  assign coin_fits = (coin_sum <= CREDIT_MAX);
  assign accept    = (lat_amt != '0) && (lat_amt <= chk_stock) && (32'(cost) <= 32'(credit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      machine_acc <= '0;
      red_light   <= 1'b0;
      coin_reject <= 1'b0;
      lat_type    <= '0;
      lat_amt     <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      machine_acc <= acc_nxt;
      red_light   <= red_nxt;
      coin_reject <= rej_nxt;
      lat_type    <= lat_type_nxt;
      lat_amt     <= lat_amt_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    acc_nxt      = machine_acc;
    red_nxt      = red_light;
    rej_nxt      = 1'b0;
    lat_type_nxt = lat_type;
    lat_amt_nxt  = lat_amt;
    cnt_nxt      = cnt;
    restock_en   = 1'b0;
    dec_en       = 1'b0;
    case (state)
      IDLE: begin
        restock_en = restock_valid;
        if (coin_valid) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            state_nxt  = COLLECT;
          end else begin
            rej_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        // A coin that loses to cancel/select on the same cycle is handed back.
        if (cancel) begin
          rej_nxt   = coin_valid;
          state_nxt = CHANGE;
        end else if (sel_valid) begin
          rej_nxt      = coin_valid;
          lat_type_nxt = sel_type;
          lat_amt_nxt  = sel_amount;
          state_nxt    = CHECK;
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            red_nxt    = 1'b0;
          end else begin
            rej_nxt = 1'b1;
          end
        end
      end
      CHECK: begin
        rej_nxt = coin_valid;
        if (accept) begin
          dec_en     = 1'b1;
          credit_nxt = credit - CREDIT_W'(cost);
          acc_nxt    = ACC_W'(sat_add(16'(machine_acc), 16'(cost), ACC_MAX));
          red_nxt    = 1'b0;
          cnt_nxt    = lat_amt;
          state_nxt  = DISPENSE;
        end else begin
          red_nxt   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      DISPENSE: begin
        rej_nxt = coin_valid;
        cnt_nxt = cnt - 1'b1;
        if (cnt == STOCK_W'(1)) state_nxt = CHANGE;
      end
      CHANGE: begin
        rej_nxt    = coin_valid;
        credit_nxt = '0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Actuator outputs decode the state directly so an async reset silences them at once.
  assign busy           = (state == CHECK) || (state == DISPENSE) || (state == CHANGE);
  assign dispense_valid = (state == DISPENSE);
  assign dispense_type  = dispense_valid ? lat_type : '0;
  assign change_valid   = (state == CHANGE);
  assign change_amount  = change_valid ? credit : '0;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller: purchase flow, rejects, saturation, async reset.
module tb_vend_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] price_flat;
  logic        coin_valid, sel_valid, cancel, restock_valid;
  logic [3:0]  coin_value;
  logic [2:0]  sel_type, restock_type, stock_rd_type;
  logic [3:0]  sel_amount, restock_qty;
  logic        busy, red_light, coin_reject, dispense_valid, change_valid;
  logic [2:0]  dispense_type;
  logic [4:0]  change_amount, credit;
  logic [7:0]  machine_acc;
  logic [3:0]  stock_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  vend_controller dut (
    .clk(clk), .rst_n(rst_n), .price_flat(price_flat),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_type(sel_type), .sel_amount(sel_amount),
    .cancel(cancel),
    .restock_valid(restock_valid), .restock_type(restock_type), .restock_qty(restock_qty),
    .busy(busy), .red_light(red_light), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_type(dispense_type),
    .change_valid(change_valid), .change_amount(change_amount),
    .credit(credit), .machine_acc(machine_acc),
    .stock_rd_type(stock_rd_type), .stock_rd_data(stock_rd_data)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_value = v;
    cyc();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [2:0] t, input logic [3:0] a);
    sel_valid = 1'b1; sel_type = t; sel_amount = a;
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic restock(input logic [2:0] t, input logic [3:0] q);
    restock_valid = 1'b1; restock_type = t; restock_qty = q;
    cyc();
    restock_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
  endtask

  task automatic peek_stock(input logic [2:0] t);
    stock_rd_type = t;
    #1;
  endtask

  // Runs until busy drops (bounded), counting dispense pulses.
  task automatic run_to_idle(output int pulses, output bit done);
    pulses = 0; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (dispense_valid) pulses++;
      if (!busy) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", busy); end
    n_cmp++; if (credit !== 5'd0) begin n_err++; $display("FAIL reset_credit got %0d want 0", credit); end
    n_cmp++; if (machine_acc !== 8'd0) begin n_err++; $display("FAIL reset_acc got %0d want 0", machine_acc); end
    n_cmp++; if ({red_light, coin_reject, dispense_valid, change_valid} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {red_light, coin_reject, dispense_valid, change_valid}); end
    n_cmp++; if ({dispense_type, change_amount} !== 8'd0) begin n_err++; $display("FAIL reset_dtype_chg got %0d/%0d want 0/0", dispense_type, change_amount); end
    peek_stock(3'd5);
    n_cmp++; if (stock_rd_data !== 4'd0) begin n_err++; $display("FAIL reset_stock got %0d want 0", stock_rd_data); end
  endtask

  task automatic test_purchase();
    restock(3'd2, 4'd5);
    peek_stock(3'd2);
    n_cmp++; if (stock_rd_data !== 4'd5) begin n_err++; $display("FAIL buy_restock got %0d want 5", stock_rd_data); end
    coin(4'd4); coin(4'd4);
    n_cmp++; if (credit !== 5'd8 || busy !== 1'b0) begin n_err++; $display("FAIL buy_credit got %0d busy %0d want 8 busy 0", credit, busy); end
    select(3'd2, 4'd2);
    n_cmp++; if (busy !== 1'b1 || dispense_valid !== 1'b0) begin n_err++; $display("FAIL buy_check got busy %0d dv %0d want 1 0", busy, dispense_valid); end
    cyc();
    n_cmp++; if (dispense_valid !== 1'b1 || dispense_type !== 3'd2) begin n_err++; $display("FAIL buy_disp1 got dv %0d type %0d want 1 2", dispense_valid, dispense_type); end
    n_cmp++; if (credit !== 5'd2 || machine_acc !== 8'd6 || stock_rd_data !== 4'd3) begin n_err++; $display("FAIL buy_commit got cr %0d acc %0d st %0d want 2 6 3", credit, machine_acc, stock_rd_data); end
    cyc();
    n_cmp++; if (dispense_valid !== 1'b1 || dispense_type !== 3'd2) begin n_err++; $display("FAIL buy_disp2 got dv %0d type %0d want 1 2", dispense_valid, dispense_type); end
    cyc();
    n_cmp++; if (dispense_valid !== 1'b0 || change_valid !== 1'b1 || change_amount !== 5'd2) begin n_err++; $display("FAIL buy_change got dv %0d cv %0d amt %0d want 0 1 2", dispense_valid, change_valid, change_amount); end
    cyc();
    n_cmp++; if (busy !== 1'b0 || credit !== 5'd0 || change_valid !== 1'b0) begin n_err++; $display("FAIL buy_idle got busy %0d cr %0d cv %0d want 0 0 0", busy, credit, change_valid); end
  endtask

  task automatic test_insufficient_credit();
    coin(4'd5);
    select(3'd2, 4'd2);
    cyc();
    n_cmp++; if (red_light !== 1'b1 || credit !== 5'd5 || busy !== 1'b0) begin n_err++; $display("FAIL nocred_reject got red %0d cr %0d busy %0d want 1 5 0", red_light, credit, busy); end
    coin(4'd1);
    n_cmp++; if (red_light !== 1'b0 || credit !== 5'd6) begin n_err++; $display("FAIL nocred_coin got red %0d cr %0d want 0 6", red_light, credit); end
    do_cancel();
    n_cmp++; if (change_valid !== 1'b1 || change_amount !== 5'd6) begin n_err++; $display("FAIL nocred_cancel got cv %0d amt %0d want 1 6", change_valid, change_amount); end
    cyc();
  endtask

  task automatic test_out_of_stock();
    restock(3'd1, 4'd1);
    coin(4'd15);
    select(3'd1, 4'd2);
    n_cmp++; if (dispense_valid !== 1'b0) begin n_err++; $display("FAIL oos_nodisp_chk got %0d want 0", dispense_valid); end
    cyc();
    peek_stock(3'd1);
    n_cmp++; if (red_light !== 1'b1 || dispense_valid !== 1'b0 || stock_rd_data !== 4'd1 || credit !== 5'd15) begin n_err++; $display("FAIL oos_reject got red %0d dv %0d st %0d cr %0d want 1 0 1 15", red_light, dispense_valid, stock_rd_data, credit); end
    coin(4'd1);
    select(3'd1, 4'd0);
    cyc();
    n_cmp++; if (red_light !== 1'b1 || credit !== 5'd16 || busy !== 1'b0) begin n_err++; $display("FAIL oos_zero got red %0d cr %0d busy %0d want 1 16 0", red_light, credit, busy); end
    do_cancel();
    n_cmp++; if (change_amount !== 5'd16) begin n_err++; $display("FAIL oos_cancel got %0d want 16", change_amount); end
    cyc();
  endtask

  task automatic test_credit_overflow();
    coin(4'd15); coin(4'd15);
    coin(4'd4);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 5'd30) begin n_err++; $display("FAIL ovf_reject got rej %0d cr %0d want 1 30", coin_reject, credit); end
    cyc();
    n_cmp++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL ovf_pulse got %0d want 0", coin_reject); end
    select(3'd2, 4'd1);
    cyc();
    coin(4'd1);
    n_cmp++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amount !== 5'd27) begin n_err++; $display("FAIL ovf_busy_coin got rej %0d cv %0d amt %0d want 1 1 27", coin_reject, change_valid, change_amount); end
    cyc();
    n_cmp++; if (machine_acc !== 8'd9) begin n_err++; $display("FAIL ovf_acc got %0d want 9", machine_acc); end
  endtask

  task automatic test_saturation();
    int  pulses, total;
    bit  done, all_done;
    restock(3'd3, 4'd12); restock(3'd3, 4'd10);
    peek_stock(3'd3);
    n_cmp++; if (stock_rd_data !== 4'd15) begin n_err++; $display("FAIL sat_stock got %0d want 15", stock_rd_data); end
    total = 0; all_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      restock(3'd4, 4'd2);
      coin(4'd15); coin(4'd15);
      select(3'd4, 4'd2);
      run_to_idle(pulses, done);
      total += pulses;
      all_done &= done;
    end
    n_cmp++; if (all_done !== 1'b1 || total !== 16) begin n_err++; $display("FAIL sat_loop got done %0d pulses %0d want 1 16", all_done, total); end
    n_cmp++; if (machine_acc !== 8'd249) begin n_err++; $display("FAIL sat_acc249 got %0d want 249", machine_acc); end
    coin(4'd1);
    select(3'd1, 4'd1);
    run_to_idle(pulses, done);
    n_cmp++; if (done !== 1'b1 || machine_acc !== 8'd250) begin n_err++; $display("FAIL sat_acc250 got done %0d acc %0d want 1 250", done, machine_acc); end
    restock(3'd7, 4'd1);
    coin(4'd15);
    select(3'd7, 4'd1);
    run_to_idle(pulses, done);
    n_cmp++; if (done !== 1'b1 || pulses != 1 || machine_acc !== 8'd255) begin n_err++; $display("FAIL sat_acc255 got done %0d p %0d acc %0d want 1 1 255", done, pulses, machine_acc); end
  endtask

  task automatic test_async_reset();
    int pulses;
    coin(4'd15);
    select(3'd2, 4'd2);
    cyc();
    n_cmp++; if (dispense_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre got %0d want 1", dispense_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dispense_valid !== 1'b0 || busy !== 1'b0 || credit !== 5'd0 || machine_acc !== 8'd0) begin n_err++; $display("FAIL arst_now got dv %0d busy %0d cr %0d acc %0d want 0 0 0 0", dispense_valid, busy, credit, machine_acc); end
    cyc();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (dispense_valid) pulses++;
    end
    peek_stock(3'd2);
    n_cmp++; if (pulses != 0 || busy !== 1'b0 || credit !== 5'd0 || stock_rd_data !== 4'd0) begin n_err++; $display("FAIL arst_after got p %0d busy %0d cr %0d st %0d want 0 0 0 0", pulses, busy, credit, stock_rd_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    coin_valid = 1'b0; coin_value = '0;
    sel_valid = 1'b0; sel_type = '0; sel_amount = '0;
    cancel = 1'b0;
    restock_valid = 1'b0; restock_type = '0; restock_qty = '0;
    stock_rd_type = '0;
    // prices: type1=1, type2=3, type4=15, type7=15, others 0
    price_flat = {4'd15, 4'd0, 4'd0, 4'd15, 4'd0, 4'd3, 4'd1, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_purchase();
    test_insufficient_credit();
    test_out_of_stock();
    test_credit_overflow();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
